// File: rtl/fft_controller_gen_if.sv
// Handshake and status bundle between the FFT sequencer and its neighbours.
// master = sequencer side, slave = buffer/FFT/status side.
interface fft_controller_gen_if #(
    parameter int N_STAGE     = 8,
    parameter int FRAME_CNT_W = 16
);
    logic                   buf_almost_rfull;
    logic                   buf_rempty;
    logic                   r_req;
    logic                   spi_en_inf_system_sync;
    logic                   out_ready;
    logic                   valid;
    logic                   fft_adv;
    logic                   frame_busy;
    logic                   frame_done;
    logic                   frame_abort;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [N_STAGE-1:0]     FSM_pre_store_en;
    logic [N_STAGE-1:0]     FSM_calc_en;
    logic [N_STAGE-1:0]     FSM_data_in_buf_ren;

    modport master (
        input  buf_almost_rfull, buf_rempty, spi_en_inf_system_sync, out_ready,
        output r_req, valid, fft_adv, frame_busy, frame_done, frame_abort,
        output frame_cnt, FSM_pre_store_en, FSM_calc_en, FSM_data_in_buf_ren
    );

    modport slave (
        output buf_almost_rfull, buf_rempty, spi_en_inf_system_sync, out_ready,
        input  r_req, valid, fft_adv, frame_busy, frame_done, frame_abort,
        input  frame_cnt, FSM_pre_store_en, FSM_calc_en, FSM_data_in_buf_ren
    );
endinterface

// File: rtl/fft_controller_gen.sv
// Frame sequencer for an N_FFT-point radix-2 SDF FFT: reads one frame,
// drains the pipeline under back-pressure, and drives per-stage enables.
module fft_controller_gen #(
    parameter int N_FFT            = 256,
    parameter int REN_EARLY_STAGES = 3,
    parameter int FRAME_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_controller_gen_if.master bus
);
    localparam int N_STAGE   = $clog2(N_FFT);
    localparam int CNT_WIDTH = $clog2(N_FFT) + 1;

    localparam logic [CNT_WIDTH-1:0] FILL_LAST  = CNT_WIDTH'(N_FFT - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(2 * N_FFT - 1);
    localparam logic [CNT_WIDTH-1:0] RD_MAX     = CNT_WIDTH'(N_FFT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [CNT_WIDTH-1:0]   counter, counter_nx;
    logic [CNT_WIDTH-1:0]   rd_issued, rd_issued_nx;
    logic                   valid_q;
    logic                   done_q, done_nx;
    logic                   abort_q, abort_nx;
    logic                   r_req, cnt_en;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [N_STAGE-1:0]     pre_en, calc_en, ren;

    function automatic logic [CNT_WIDTH-1:0] ren_thr(input int i);
        int t;
        t = N_FFT - (N_FFT >> (i + 1)) - ((i < REN_EARLY_STAGES) ? 1 : 0);
        return CNT_WIDTH'(t);
    endfunction

    always_comb begin
        state_nx     = state;
        counter_nx   = counter;
        rd_issued_nx = rd_issued;
        r_req        = 1'b0;
        cnt_en       = 1'b0;
        done_nx      = 1'b0;
        abort_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                counter_nx   = '0;
                rd_issued_nx = '0;
                if (bus.buf_almost_rfull && bus.spi_en_inf_system_sync)
                    state_nx = FILL;
            end
            FILL: begin
                r_req  = ~bus.buf_rempty & (rd_issued < RD_MAX);
                cnt_en = valid_q;
                if (r_req)
                    rd_issued_nx = rd_issued + 1'b1;
                if (valid_q)
                    counter_nx = counter + 1'b1;
                if (valid_q && counter == FILL_LAST)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                cnt_en = bus.out_ready;
                if (bus.out_ready) begin
                    if (counter == DRAIN_LAST) begin
                        counter_nx   = '0;
                        rd_issued_nx = '0;
                        done_nx      = 1'b1;
                        state_nx     = IDLE;
                    end else begin
                        counter_nx = counter + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Losing the enable abandons the frame; any in-flight sample is dropped.
        if (state != IDLE && !bus.spi_en_inf_system_sync) begin
            state_nx     = IDLE;
            counter_nx   = '0;
            rd_issued_nx = '0;
            r_req        = 1'b0;
            cnt_en       = 1'b0;
            done_nx      = 1'b0;
            abort_nx     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            counter   <= '0;
            rd_issued <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nx;
            counter   <= counter_nx;
            rd_issued <= rd_issued_nx;
            valid_q   <= r_req;
            done_q    <= done_nx;
            abort_q   <= abort_nx;
            if (done_nx)
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

    always_comb begin
        pre_en  = '0;
        calc_en = '0;
        ren     = '0;
        for (int i = 0; i < N_STAGE; i++) begin
            pre_en[i]  = ~counter[N_STAGE-1-i];
            calc_en[i] = counter[N_STAGE-1-i];
            ren[i]     = (counter >= ren_thr(i));
        end
    end

    assign bus.r_req               = r_req;
    assign bus.valid               = valid_q;
    assign bus.fft_adv             = cnt_en;
    assign bus.frame_busy          = (state != IDLE);
    assign bus.frame_done          = done_q;
    assign bus.frame_abort         = abort_q;
    assign bus.frame_cnt           = frame_cnt;
    assign bus.FSM_pre_store_en    = pre_en;
    assign bus.FSM_calc_en         = calc_en;
    assign bus.FSM_data_in_buf_ren = ren;
endmodule

// File: doc/fft_controller_gen.md
Name: fft_controller_gen

Overview:
- Parametrised successor of the fixed 256-point FFT sequencer in the feature extractor.
- Drives sample reads from the frame data buffer and generates per-stage pre-store, calculate and input-buffer read enables for an N_FFT-point radix-2 SDF pipeline.
- Adds behaviour the fixed sequencer lacks:
  - exact read-issue accounting, so reads never exceed N_FFT;
  - output back-pressure that freezes the drain phase;
  - frame done/abort status and a frame counter;
  - a generic formula for the input-buffer read thresholds.

Parameters:
- N_FFT, 256, FFT length; power of two, 8..4096.
- REN_EARLY_STAGES, 3, number of leading stages whose buffer read enable asserts one count early (pipeline alignment); 0..N_STAGE.
- FRAME_CNT_W, 16, width of the frame counter.
- N_STAGE (localparam), $clog2(N_FFT).
- CNT_WIDTH (localparam), $clog2(N_FFT)+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- buf_almost_rfull  in  1  buffer holds at least one frame; starts a frame
- buf_rempty  in  1  buffer empty
- r_req  out  1  buffer read request; one sample per asserted cycle
- spi_en_inf_system_sync  in  1  inference enable, already synchronised; 0 aborts the current frame
- out_ready  in  1  downstream accepts FFT output; only sampled in DRAIN
- valid  out  1  sample valid into the FFT; equals r_req delayed one cycle
- fft_adv  out  1  global advance enable for the FFT pipeline (equals the internal cnt_en)
- frame_busy  out  1  state is not IDLE
- frame_done  out  1  one-cycle pulse when a frame completes normally
- frame_abort  out  1  one-cycle pulse when a frame is abandoned
- frame_cnt  out  FRAME_CNT_W  number of completed frames; wraps
- FSM_pre_store_en  out  N_STAGE  per-stage pre-store enable
- FSM_calc_en  out  N_STAGE  per-stage butterfly enable
- FSM_data_in_buf_ren  out  N_STAGE  per-stage input-buffer read enable

Behaviour:
- Reset values: state IDLE; counter=0, rd_issued=0; r_req=0, valid=0, fft_adv=0, frame_busy=0, frame_done=0, frame_abort=0, frame_cnt=0.
- Per-stage enables are combinational from counter. Their reset values follow from counter=0: pre_store_en all 1, calc_en all 0, buf_ren all 0 (for N_FFT≥8).
- States IDLE, FILL, DRAIN, encoded in 2 bits. Transitions are registered.
- IDLE:
  - counter=0, rd_issued=0.
  - Go to FILL when buf_almost_rfull=1 and spi_en_inf_system_sync=1.
- FILL:
  - r_req = ~buf_rempty & (rd_issued < N_FFT).
  - rd_issued increments on each r_req.
  - counter increments on each valid; fft_adv=valid.
  - Go to DRAIN on the cycle valid=1 and counter==N_FFT-1. The counter still increments to N_FFT on that edge.
- DRAIN:
  - r_req=0; fft_adv=out_ready; counter increments only when out_ready=1.
  - Go to IDLE when counter==2*N_FFT-1 and out_ready=1. On that same edge: frame_done pulses, frame_cnt increments, counter clears.
- Abort: spi_en_inf_system_sync=0 in FILL or DRAIN →
  - next state IDLE, frame_abort pulses for one cycle, counter and rd_issued clear, frame_cnt is unchanged;
  - r_req is forced to 0 in the abort cycle;
  - a valid already in flight is ignored.
- Enables, for stage i (counter bit index N_STAGE-1-i):
  - FSM_pre_store_en[i] = (counter[N_STAGE-1-i]==0);
  - FSM_calc_en[i] = (counter[N_STAGE-1-i]==1);
  - FSM_data_in_buf_ren[i] = counter ≥ N_FFT - (N_FFT>>(i+1)) - (i<REN_EARLY_STAGES ? 1 : 0).
- For N_FFT=256 the buf_ren thresholds are 127, 191, 223, 240, 248, 252, 254, 255.
- Widths: counter is CNT_WIDTH bits and never exceeds 2*N_FFT-1. rd_issued is CNT_WIDTH bits and saturates at N_FFT.
- Buffer empty during FILL: r_req deasserts, counter holds, and the state remains FILL indefinitely.
- buf_almost_rfull is ignored outside IDLE.
- Reset asserted mid-frame returns every register to its reset value immediately (asynchronously).

Test Plan:
- N_FFT=256, buffer never empty, out_ready=1 → r_req high exactly 256 cycles; valid lags by 1; frame_done pulses once 513 cycles after entry to FILL; frame_cnt=1.
- N_FFT=256, buf_rempty toggles every other cycle during FILL → exactly 256 r_req pulses total, no 257th; DRAIN entered only after the 256th valid.
- Drain stall: out_ready=0 for 10 cycles at counter=300 → counter and all enables frozen for those 10 cycles; frame_done delayed by exactly 10 cycles.
- Abort: drop spi_en_inf_system_sync at counter=100 in FILL → next cycle state IDLE, frame_abort=1 for one cycle, frame_cnt unchanged, r_req=0; a new frame starts cleanly once the enable returns.
- Enable sweep, N_FFT=16, REN_EARLY_STAGES=1 → buf_ren thresholds 7, 12, 14, 15; pre_store/calc follow counter bits 3..0; checked at every counter value 0..31.
- Reset asserted in DRAIN at counter=400 → all outputs return to reset values asynchronously; no frame_done pulse.
